data_sram_responder: RTL and testbench

Slave (responder) end of the data-side SRAM-like request/response interface driven by the EXE stage (request) and consumed by the MEM stage (response). Accepts read/write requests on an address handshake, applies writes with byte strobes, and returns each response in order after a fixed latency on a data handshake. It serves as the data-memory model behind the pipeline in simulation and as a drop-in on-chip data RAM in FPGA builds. MEM performs all byte/half extraction, so the block always returns the full aligned word.

---
 rtl/data_sram_responder.sv | 90 +++++++++
 tb/tb_data_sram_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data-side SRAM-like responder: a word-wide RAM with byte-strobe writes behind an
// address handshake, and in-order responses after a fixed latency on a data handshake.
module data_sram_responder #(
  parameter int AW     = 10,
  parameter int LAT    = 2,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int              PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [2:0]      QD     = 3'(QDEPTH);
  localparam logic [3:0]      LAT_M1 = 4'(LAT - 1);
  localparam logic [PW-1:0]   LAST   = PW'(QDEPTH - 1);

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] idx;

  logic          q_wr   [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [3:0]    q_cnt  [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [2:0]    count;

  logic accept;
  logic pop;

  // Size and the sub-word/upper address bits carry no meaning here; MEM extracts lanes.
  logic unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign idx               = data_sram_addr[AW+1:2];
  assign data_sram_addr_ok = (count < QD);
  assign accept            = resetn && data_sram_req && data_sram_addr_ok;
  assign data_sram_data_ok = (count != 3'd0) && (q_cnt[head] == 4'd0);
  assign pop               = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !q_wr[head]) ? q_data[head] : 32'd0;

  // Queue control. Free slots always hold cnt = 0 (they only ever leave via a pop at
  // zero), so decrementing every non-zero counter touches exactly the live entries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) q_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++)
        if (q_cnt[i] != 4'd0) q_cnt[i] <= q_cnt[i] - 4'd1;
      if (accept) begin
        q_cnt[tail] <= LAT_M1;
        tail        <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      if (accept && !pop)      count <= count + 3'd1;
      else if (!accept && pop) count <= count - 3'd1;
    end
  end

  // NOTE: the RAM array and queue payloads are deliberately outside the reset; clearing
  // a memory in reset turns it into a huge flop bank and mid-run reset must keep writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[tail] <= data_sram_wr;
      if (data_sram_wr) begin
        for (int b = 0; b < 4; b++)
          if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        q_data[tail] <= 32'd0;
      end else begin
        q_data[tail] <= mem[idx];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (LAT 2/3/1, QDEPTH 2) checked against a
// timestamped response scoreboard and a byte-level memory model.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        req     [3];
  logic        wr      [3];
  logic [1:0]  size    [3];
  logic [3:0]  wstrb   [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic        addr_ok [3];
  logic        data_ok [3];
  logic [31:0] rdata   [3];

  int lat    [3] = '{2, 3, 1};
  int qdepth [3] = '{2, 2, 2};

  data_sram_responder #(.AW(10), .LAT(2), .QDEPTH(2)) u0 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_size(size[0]), .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]),
    .data_sram_wdata(wdata[0]), .data_sram_addr_ok(addr_ok[0]),
    .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0]));
  data_sram_responder #(.AW(10), .LAT(3), .QDEPTH(2)) u1 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_size(size[1]), .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]),
    .data_sram_wdata(wdata[1]), .data_sram_addr_ok(addr_ok[1]),
    .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1]));
  data_sram_responder #(.AW(10), .LAT(1), .QDEPTH(2)) u2 (
    .clk(clk), .resetn(resetn), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
    .data_sram_size(size[2]), .data_sram_wstrb(wstrb[2]), .data_sram_addr(addr[2]),
    .data_sram_wdata(wdata[2]), .data_sram_addr_ok(addr_ok[2]),
    .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: per-instance word memory plus a list of expected responses, each
  // stamped with the negedge cycle at which its data_ok must be seen.
  typedef struct { int k; int due; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] mmem [3][1024];

  int          n_checks = 0;
  int          n_pass   = 0;
  bit          mon_en   = 0;
  int          pulse_cnt  [3] = '{0, 0, 0};
  int          acc_cnt    [3] = '{0, 0, 0};
  int          acc_first  [3] = '{-1, -1, -1};
  int          acc_last   [3] = '{0, 0, 0};
  int          stall      [3] = '{0, 0, 0};
  logic [31:0] last_rdata [3];
  logic [31:0] resp1_log[$];

  function automatic int occ(input int k);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].k == k) n++;
    return n;
  endfunction

  function automatic int head_of(input int k);
    foreach (exp_q[i]) if (exp_q[i].k == k) return i;
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    int          h;
    int          o [3];
    logic [31:0] w;
    logic [9:0]  ix;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        o[k] = occ(k);
        h    = head_of(k);
        n_checks++;
        if (addr_ok[k] !== (o[k] < qdepth[k]))
          $display("FAIL addr_ok inst%0d cyc %0d: got %b expected %b", k, cyc, addr_ok[k], o[k] < qdepth[k]);
        else n_pass++;
        if (data_ok[k] === 1'b1) begin
          pulse_cnt[k]++;
          last_rdata[k] = rdata[k];
          if (k == 1) resp1_log.push_back(rdata[k]);
          n_checks++;
          if (h < 0 || exp_q[h].due != cyc)
            $display("FAIL data_ok inst%0d cyc %0d: pulse got, expected due %0d", k, cyc, (h < 0) ? -1 : exp_q[h].due);
          else if (rdata[k] !== exp_q[h].data)
            $display("FAIL rdata inst%0d cyc %0d: got %h expected %h", k, cyc, rdata[k], exp_q[h].data);
          else n_pass++;
          if (h >= 0) exp_q.delete(h);
        end else begin
          n_checks++;
          if (data_ok[k] !== 1'b0 || rdata[k] !== 32'h0)
            $display("FAIL idle outputs inst%0d cyc %0d: data_ok %b rdata %h expected 0/0", k, cyc, data_ok[k], rdata[k]);
          else if (h >= 0 && exp_q[h].due == cyc) begin
            $display("FAIL missing data_ok inst%0d cyc %0d: got 0 expected 1", k, cyc);
            exp_q.delete(h);
          end else n_pass++;
        end
      end
      if (!resetn) exp_q.delete();
      else begin
        for (int k = 0; k < 3; k++) begin
          if (req[k] && o[k] < qdepth[k]) begin
            ix = addr[k][11:2];
            if (wr[k]) begin
              w = mmem[k][ix];
              for (int b = 0; b < 4; b++) if (wstrb[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
              mmem[k][ix] = w;
              exp_q.push_back('{k: k, due: cyc + lat[k], data: 32'h0});
            end else begin
              exp_q.push_back('{k: k, due: cyc + lat[k], data: mmem[k][ix]});
            end
            acc_cnt[k]++;
            if (acc_first[k] < 0) acc_first[k] = cyc;
            acc_last[k] = cyc;
          end else if (req[k]) stall[k]++;
        end
      end
    end
  end

  task automatic preload(input int k, input logic [9:0] i, input logic [31:0] v);
    mmem[k][i] = v;
    case (k)
      0:       u0.mem[i] = v;
      1:       u1.mem[i] = v;
      default: u2.mem[i] = v;
    endcase
  endtask

  // Presents one request and holds it until the handshake; returns at posedge+1.
  task automatic send(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, output int waits);
    bit ok = 0;
    waits = 0;
    req[k] = 1'b1; wr[k] = w; wstrb[k] = s; addr[k] = a; wdata[k] = d;
    size[k] = 2'($urandom_range(0, 3));
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (addr_ok[k] === 1'b1 && resetn === 1'b1) ok = 1;
      else waits++;
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send timeout inst%0d addr %h: got no addr_ok expected accept", k, a);
    end
  endtask

  task automatic drain(input int k);
    int i = 0;
    while (occ(k) != 0 && i < 60) begin
      @(negedge clk); #1;
      i++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (occ(k) != 0) $display("FAIL drain timeout inst%0d: got %0d outstanding expected 0", k, occ(k));
    else n_pass++;
  endtask

  task automatic test_reset();
    int waits;
    @(posedge clk); #1;
    mon_en = 1;
    req[0] = 1'b1; wr[0] = 1'b1; wstrb[0] = 4'hF; addr[0] = 32'h80; wdata[0] = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (addr_ok[0] !== 1'b1 || data_ok[0] !== 1'b0 || rdata[0] !== 32'h0)
        $display("FAIL reset outputs: got %b/%b/%h expected 1/0/00000000", addr_ok[0], data_ok[0], rdata[0]);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (u0.mem[32] !== mmem[0][32]) $display("FAIL reset mem: got %h expected %h", u0.mem[32], mmem[0][32]);
    else n_pass++;
    resetn = 1'b1;
    send(0, 1'b1, 4'hF, 32'h80, 32'hDEADBEEF, waits);
    n_checks++;
    if (waits != 0) $display("FAIL first accept after reset: got %0d waits expected 0", waits);
    else n_pass++;
    send(0, 1'b0, 4'h0, 32'h80, 32'h0, waits);
    drain(0);
    n_checks++;
    if (last_rdata[0] !== 32'hDEADBEEF) $display("FAIL reset readback: got %h expected deadbeef", last_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_word_rw();
    int waits;
    int p0 = pulse_cnt[0];
    send(0, 1'b1, 4'hF, 32'h1C, 32'h12345678, waits);
    send(0, 1'b0, 4'h0, 32'h1C, 32'h0, waits);
    drain(0);
    n_checks++;
    if (pulse_cnt[0] - p0 != 2) $display("FAIL word pulses: got %0d expected 2", pulse_cnt[0] - p0);
    else n_pass++;
    n_checks++;
    if (last_rdata[0] !== 32'h12345678) $display("FAIL word read: got %h expected 12345678", last_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_byte_strobes();
    int waits;
    preload(0, 10'h10, 32'hAABBCCDD);
    send(0, 1'b1, 4'h4, 32'h40, 32'h00110000, waits);
    send(0, 1'b0, 4'h0, 32'h40, 32'h0, waits);
    drain(0);
    n_checks++;
    if (last_rdata[0] !== 32'hAA11CCDD) $display("FAIL strobe merge: got %h expected aa11ccdd", last_rdata[0]);
    else n_pass++;
    send(0, 1'b1, 4'h0, 32'h40, $urandom, waits);
    send(0, 1'b0, 4'h0, 32'h40, 32'h0, waits);
    drain(0);
    n_checks++;
    if (last_rdata[0] !== 32'hAA11CCDD) $display("FAIL zero strobe: got %h expected aa11ccdd", last_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_full_queue();
    int          waits;
    int          p0 = pulse_cnt[1];
    logic [31:0] pre [4];
    for (int i = 0; i < 4; i++) begin
      pre[i] = $urandom;
      preload(1, 10'(i), pre[i]);
    end
    resp1_log.delete();
    stall[1] = 0;
    for (int i = 0; i < 4; i++) send(1, 1'b0, 4'h0, 32'(i * 4), 32'h0, waits);
    drain(1);
    n_checks++;
    if (pulse_cnt[1] - p0 != 4) $display("FAIL full-queue pulses: got %0d expected 4", pulse_cnt[1] - p0);
    else n_pass++;
    n_checks++;
    if (stall[1] == 0) $display("FAIL full-queue stall: got 0 stalled cycles expected >0");
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp1_log.size() <= i || resp1_log[i] !== pre[i])
        $display("FAIL full-queue order %0d: got %h expected %h", i, (resp1_log.size() > i) ? resp1_log[i] : 32'hx, pre[i]);
      else n_pass++;
    end
  endtask

  task automatic test_lat1_stream();
    int         waits;
    int         p0 = pulse_cnt[2];
    logic       w;
    logic [31:0] a;
    acc_cnt[2] = 0; acc_first[2] = -1;
    for (int i = 0; i < 16; i++) begin
      w = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      a = (i < 2) ? 32'h0 : 32'($urandom_range(0, 3)) << 2;
      send(2, w, 4'($urandom), a, $urandom, waits);
    end
    drain(2);
    n_checks++;
    if (acc_cnt[2] != 16 || acc_last[2] - acc_first[2] != 15)
      $display("FAIL stream rate: got %0d accepts over %0d cycles expected 16 over 15", acc_cnt[2], acc_last[2] - acc_first[2]);
    else n_pass++;
    n_checks++;
    if (pulse_cnt[2] - p0 != 16) $display("FAIL stream pulses: got %0d expected 16", pulse_cnt[2] - p0);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    int          waits;
    int          p0;
    logic [31:0] v = $urandom;
    send(1, 1'b1, 4'hF, 32'h200, v, waits);
    drain(1);
    p0 = pulse_cnt[1];
    send(1, 1'b0, 4'h0, 32'h0, 32'h0, waits);
    send(1, 1'b0, 4'h0, 32'h4, 32'h0, waits);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_cnt[1] != p0) $display("FAIL midflight pulses: got %0d expected 0", pulse_cnt[1] - p0);
    else n_pass++;
    n_checks++;
    if (u1.count !== 3'd0) $display("FAIL midflight count: got %0d expected 0", u1.count);
    else n_pass++;
    send(1, 1'b0, 4'h0, 32'h200, 32'h0, waits);
    drain(1);
    n_checks++;
    if (last_rdata[1] !== v) $display("FAIL midflight write kept: got %h expected %h", last_rdata[1], v);
    else n_pass++;
  endtask

  initial begin
    clk = 1'b0;
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd2; wstrb[k] = 4'h0; addr[k] = 32'h0; wdata[k] = 32'h0;
      last_rdata[k] = 32'h0;
    end
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 3; k++) preload(k, 10'(i), $urandom);
    test_reset();
    test_word_rw();
    test_byte_strobes();
    test_full_queue();
    test_lat1_stream();
    test_reset_midflight();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
